// File: rtl/mult_pipe_ext.sv
// mult_pipe_ext: back-pressured pipelined integer multiplier for the multiply functional unit.
// Produces the low (MUL) or high (MULH/MULHSU/MULHU) half of a WIDTH x WIDTH product and
// carries a destination tag with every operation.
//
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   in_valid/in_ready     issue handshake; in_ready = !out_valid || out_ready
//   in_mcand, in_mplier   rs1 / rs2 operands
//   in_func               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_tag                destination tag carried alongside the op
//   flush                 squash all in-flight ops and the op offered this cycle
//   out_valid/out_ready   result handshake towards the CDB arbiter
//   out_result, out_tag   selected product half and its tag
module mult_pipe_ext #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mcand,
   input  logic [WIDTH-1:0] in_mplier,
   input  logic [1:0]       in_func,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned PW = 2 * WIDTH;     // full product width
   localparam int unsigned CH = PW / STAGES;   // multiplier bits consumed per stage

   logic          adv;
   logic          accept;
   logic [PW-1:0] mcand_ext;
   logic [PW-1:0] mplier_ext;

   // The whole pipe moves in lockstep; bubbles advance too, so only the output decides.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv && !flush;

   // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
   always_comb begin
      mcand_ext  = {{WIDTH{1'b0}}, in_mcand};
      mplier_ext = {{WIDTH{1'b0}}, in_mplier};
      if (in_func == 2'b01 || in_func == 2'b10) begin
         mcand_ext = {{WIDTH{in_mcand[WIDTH-1]}}, in_mcand};
      end
      if (in_func == 2'b01) begin
         mplier_ext = {{WIDTH{in_mplier[WIDTH-1]}}, in_mplier};
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_q;
      logic [TAG_W-1:0] tag_q;
      logic [1:0]       func_q;
      logic [PW-1:0]    sum_q;

      logic             src_v;
      logic [TAG_W-1:0] src_tag;
      logic [1:0]       src_func;
      logic [PW-1:0]    src_sum;
      logic [PW-1:0]    src_mcand;
      logic [PW-1:0]    src_mplier;

      logic [PW-1:0]    sum_d;
      logic [PW-1:0]    mcand_d;
      logic [PW-1:0]    mplier_d;

      if (k == 0) begin : g_head
         assign src_v      = accept;
         assign src_tag    = in_tag;
         assign src_func   = in_func;
         assign src_sum    = '0;
         assign src_mcand  = mcand_ext;
         assign src_mplier = mplier_ext;
      end else begin : g_body
         assign src_v      = g_stage[k-1].v_q;
         assign src_tag    = g_stage[k-1].tag_q;
         assign src_func   = g_stage[k-1].func_q;
         assign src_sum    = g_stage[k-1].sum_q;
         assign src_mcand  = g_stage[k-1].g_carry.mcand_q;
         assign src_mplier = g_stage[k-1].g_carry.mplier_q;
      end

      // Radix-2^CH step: the chunk product is already shifted because mcand was pre-shifted.
      always_comb begin
         sum_d    = src_sum + src_mcand * PW'(src_mplier[CH-1:0]);
         mcand_d  = src_mcand << CH;
         mplier_d = src_mplier >> CH;
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            v_q    <= 1'b0;
            tag_q  <= '0;
            func_q <= '0;
            sum_q  <= '0;
         end else if (flush) begin
            v_q <= 1'b0;
         end else if (adv) begin
            v_q    <= src_v;
            tag_q  <= src_tag;
            func_q <= src_func;
            sum_q  <= sum_d;
         end
      end

      if (k < STAGES - 1) begin : g_carry
         logic [PW-1:0] mcand_q;
         logic [PW-1:0] mplier_q;

         always_ff @(posedge clock) begin
            if (reset) begin
               mcand_q  <= '0;
               mplier_q <= '0;
            end else if (adv) begin
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
            end
         end
      end else begin : g_tail
         // Final stage has no successor for the shifted operands.
         logic unused_tail;
         assign unused_tail = ^{mcand_d, mplier_d};
      end
   end

   assign out_valid  = g_stage[STAGES-1].v_q;
   assign out_tag    = g_stage[STAGES-1].tag_q;
   assign out_result = (g_stage[STAGES-1].func_q == 2'b00) ? g_stage[STAGES-1].sum_q[WIDTH-1:0]
                                                           : g_stage[STAGES-1].sum_q[PW-1:WIDTH];

endmodule

// File: tb/tb_mult_pipe_ext.sv
// Self-checking bench for mult_pipe_ext: directed corner products, back-to-back issue, stall,
// flush, and a randomized stream with a mid-stream reset, all checked against an in-order
// queue of exact products whose arrival time follows the advance rule.
module tb_mult_pipe_ext;

   localparam int unsigned W  = 64;
   localparam int unsigned S  = 4;
   localparam int unsigned TW = 6;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_mcand;
   logic [W-1:0]  in_mplier;
   logic [1:0]    in_func;
   logic [TW-1:0] in_tag;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic [TW-1:0] out_tag;

   always #5 clock = ~clock;

   mult_pipe_ext #(
      .WIDTH (W),
      .STAGES(S),
      .TAG_W (TW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mcand  (in_mcand),
      .in_mplier (in_mplier),
      .in_func   (in_func),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_result(out_result),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [W-1:0]  res;
      logic [TW-1:0] tag;
      int unsigned   start;
   } exp_t;

   exp_t        q[$];
   int unsigned advcnt = 0;
   int          errors = 0;
   int          checks = 0;

   // Exact product in a width that cannot overflow, then pick the requested half.
   function automatic logic [W-1:0] ref_mul(input logic [1:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic signed [2*W+1:0] sa, sb, p;
      sa = (f == 2'b01 || f == 2'b10) ? signed'({{(W+2){a[W-1]}}, a})
                                      : signed'({{(W+2){1'b0}}, a});
      sb = (f == 2'b01) ? signed'({{(W+2){b[W-1]}}, b}) : signed'({{(W+2){1'b0}}, b});
      p  = sa * sb;
      return (f == 2'b00) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 4))
         0:       v = '1;
         1:       v = {1'b1, {(W-1){1'b0}}};
         2:       v = '0;
         3:       v = W'($urandom_range(0, 15));
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   // One clock: check outputs mid-cycle against the model, then update the model for the edge.
   task automatic cycle();
      logic ev;
      logic adv;
      exp_t e;
      @(negedge clock);
      ev = (q.size() > 0) && ((advcnt - q[0].start) >= S);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !ev || out_ready);
      if (ev) begin
         chk("out_tag", out_tag, q[0].tag);
         chk("out_result", out_result, q[0].res);
      end
      adv = !reset && !flush && (!ev || out_ready);
      if (adv && ev) void'(q.pop_front());
      if (adv && in_valid) begin
         e.res   = ref_mul(in_func, in_mcand, in_mplier);
         e.tag   = in_tag;
         e.start = advcnt;
         q.push_back(e);
      end
      if (adv) advcnt++;
      if (reset || flush) q.delete();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t);
      in_valid  = 1'b1;
      in_func   = f;
      in_mcand  = a;
      in_mplier = b;
      in_tag    = t;
   endtask

   // Issue one op into an idle pipe and check its latency and value.
   task automatic single(input string name, input logic [1:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] t,
                         input logic [W-1:0] exp);
      int n;
      drive(f, a, b, t);
      cycle();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      chk({name, "_lat"}, n, S);
      chk({name, "_res"}, out_result, exp);
      chk({name, "_tag"}, out_tag, t);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (S + 3) cycle();
   endtask

   initial begin
      int first, last, nseen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_mcand  = '0;
      in_mplier = '0;
      in_func   = 2'b00;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, '0);
      chk("rst_out_tag", out_tag, '0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Corner products.
      single("mulhu_ones", 2'b11, '1, '1, 6'd1, 64'hFFFF_FFFF_FFFF_FFFE);
      single("mul_ones", 2'b00, '1, '1, 6'd2, 64'h1);
      single("mulh_ones", 2'b01, '1, '1, 6'd3, 64'h0);
      single("mulhsu_ones", 2'b10, '1, '1, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF);
      single("mulh_minneg", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd5,
             64'h4000_0000_0000_0000);
      drain();

      // Back-to-back issue: eight results on consecutive cycles, in tag order.
      first = -1;
      last  = -1;
      nseen = 0;
      for (int i = 0; i < 8 + S + 2; i++) begin
         if (i < 8) drive(2'($urandom_range(0, 3)), pick(), pick(), TW'(i));
         else in_valid = 1'b0;
         cycle();
         if (out_valid) begin
            chk("b2b_tag", out_tag, TW'(nseen));
            if (first < 0) first = i;
            last = i;
            nseen++;
         end
      end
      chk("b2b_count", nseen, 8);
      chk("b2b_span", last - first + 1, 8);
      drain();

      // Stall with a full pipe, then release.
      out_ready = 1'b0;
      for (int i = 0; i < S + 6; i++) begin
         drive(2'($urandom_range(0, 3)), pick(), pick(), TW'(16 + i));
         cycle();
      end
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      drain();

      // Flush with three ops in flight and one offered.
      for (int i = 0; i < 3; i++) begin
         drive(2'($urandom_range(0, 3)), pick(), pick(), TW'(40 + i));
         cycle();
      end
      drive(2'b11, '1, '1, 6'd43);
      flush = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 1'b0);
      single("post_flush", 2'b00, 64'd12345, 64'd678, 6'd44, 64'd8369910);
      drain();

      // Random stream with stalls, flushes and one reset mid-stream.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) drive(2'($urandom_range(0, 3)), pick(), pick(),
                                              TW'($urandom()));
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         reset     = (i == 200);
         cycle();
         if (i == 200) begin
            reset = 1'b0;
            chk("midrst_out_valid", out_valid, 1'b0);
            chk("midrst_out_result", out_result, '0);
            chk("midrst_out_tag", out_tag, '0);
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
